// File: rtl/rand_arbiter.sv
// ---------------------------------------------------------------------------
// rand_arbiter
//
// Shares one 5-bit Fibonacci LFSR (x^5 + x^2 + 1, period 31) among NREQ
// requesters with a round-robin req/gnt handshake. The block owns the LFSR:
// it only shifts while serving a grant (STIR shifts per grant), accepts
// run-time reseeding while idle and never lets the register lock up at zero.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   STIR  LFSR shifts performed per grant (1..7)
//   SEED  LFSR reset value, also substituted for any zero seed
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req        request per requester, held until its gnt bit is seen
//   seed_load  single-cycle pulse, loads seed into the LFSR (IDLE only)
//   seed       seed value sampled with seed_load
//   gnt        one-hot grant, single-cycle pulse
//   rvalid     high in the same cycle as gnt
//   rdata      random value for the granted requester, held until next grant
//   busy       high while a grant is being prepared or delivered
// ---------------------------------------------------------------------------
module rand_arbiter #(
    parameter int         NREQ = 4,
    parameter int         STIR = 3,
    parameter logic [4:0] SEED = 5'h0F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            seed_load,
    input  logic [4:0]      seed,
    output logic [NREQ-1:0] gnt,
    output logic            rvalid,
    output logic [4:0]      rdata,
    output logic            busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      lfsr_q, lfsr_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rvalid_q, rvalid_d;
    logic [4:0]      rdata_q, rdata_d;
    logic            busy_q, busy_d;

    logic [4:0]      lfsr_step;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    // One LFSR shift; a zero register would stay zero forever, so it is
    // replaced by SEED instead of being shifted.
    assign lfsr_step = (lfsr_q == 5'd0) ? SEED : {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[1]};

    // Round-robin pick: scan last+1, last+2, ... modulo NREQ. The scan runs
    // from the farthest slot down so the nearest asserted request is the
    // last one written and therefore wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[IW'(idx)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    // Next-state logic. gnt/rvalid/rdata are computed on the last STEP
    // cycle so that the registered outputs are valid exactly while the
    // state register reads DELIVER.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        last_d   = last_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // A seed load takes priority; a held request is served on
                // the following cycle.
                if (seed_load) begin
                    lfsr_d = (seed == 5'd0) ? SEED : seed;
                end else if (pick_valid) begin
                    sel_d   = pick_idx;
                    cnt_d   = 3'd0;
                    state_d = STEP;
                    busy_d  = 1'b1;
                end
            end

            STEP: begin
                lfsr_d = lfsr_step;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'(STIR - 1)) begin
                    state_d  = DELIVER;
                    gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;
                    rvalid_d = 1'b1;
                    rdata_d  = lfsr_step;
                end
            end

            DELIVER: begin
                last_d  = sel_q;
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            last_q   <= IW'(NREQ - 1);
            sel_q    <= '0;
            cnt_q    <= 3'd0;
            gnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 5'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rand_arbiter
//
// Self-checking bench for rand_arbiter. Instance A (NREQ=4, STIR=3) is driven
// from a vector table and hand-written sequences; every expected grant is
// pushed to a scoreboard queue and popped by a monitor when rvalid/gnt
// appears. Instance B (NREQ=2, STIR=1) walks the full LFSR period.
// ---------------------------------------------------------------------------
module tb_rand_arbiter;

    localparam int         NREQ_A = 4;
    localparam int         STIR_A = 3;
    localparam int         NREQ_B = 2;
    localparam int         STIR_B = 1;
    localparam logic [4:0] SEED   = 5'h0F;

    logic              clk;
    logic              rst;
    logic [NREQ_A-1:0] req_a;
    logic              seed_load_a;
    logic [4:0]        seed_a;
    logic [NREQ_A-1:0] gnt_a;
    logic              rvalid_a;
    logic [4:0]        rdata_a;
    logic              busy_a;

    logic [NREQ_B-1:0] req_b;
    logic              seed_load_b;
    logic [4:0]        seed_b;
    logic [NREQ_B-1:0] gnt_b;
    logic              rvalid_b;
    logic [4:0]        rdata_b;
    logic              busy_b;

    rand_arbiter #(.NREQ(NREQ_A), .STIR(STIR_A), .SEED(SEED)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req_a),
        .seed_load (seed_load_a),
        .seed      (seed_a),
        .gnt       (gnt_a),
        .rvalid    (rvalid_a),
        .rdata     (rdata_a),
        .busy      (busy_a)
    );

    rand_arbiter #(.NREQ(NREQ_B), .STIR(STIR_B), .SEED(SEED)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .seed_load (seed_load_b),
        .seed      (seed_b),
        .gnt       (gnt_b),
        .rvalid    (rvalid_b),
        .rdata     (rdata_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [4:0] rdata;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       sl;
        logic [4:0] seed;
        logic [3:0] gnt;
        logic [4:0] rdata;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   grants_a   = 0;
    int   grant_cyc_a = 0;

    // Bench-side reference model state for instance A.
    logic [4:0] mq;
    int         mlast;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event did not occur within budget (t=%0t)", name, $time);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic sl, input logic [4:0] s);
        req_a       = r;
        seed_load_a = sl;
        seed_a      = s;
    endtask

    function automatic logic [4:0] lfsrNext(input logic [4:0] q);
        if (q == 5'd0) return SEED;
        return {q[3:0], q[4] ^ q[1]};
    endfunction

    function automatic int rrPick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NREQ_A; k++) begin
            logic [1:0] ix;
            ix = 2'((last + k) % NREQ_A);
            if (r[ix]) return int'(ix);
        end
        return -1;
    endfunction

    // Predict the next grant of instance A for request pattern r and queue it.
    task automatic pushPrediction(input logic [3:0] r);
        exp_t e;
        int   sel;
        sel = rrPick(r, mlast);
        for (int s = 0; s < STIR_A; s++) mq = lfsrNext(mq);
        e.gnt   = 4'b0001 << sel;
        e.rdata = mq;
        sbq.push_back(e);
        mlast = sel;
    endtask

    task automatic waitGrantA(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (grants_a >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("grant_timeout_a");
    endtask

    task automatic waitGrantB(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (rvalid_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("grant_timeout_b");
    endtask

    // Scoreboard monitor for instance A: any grant must match the oldest
    // queued expectation.
    always @(negedge clk) begin
        if (rvalid_a || (gnt_a != 4'd0)) begin
            if (sbq.size() == 0) begin
                failNow("unexpected_grant_a");
            end else begin
                mon_e = sbq.pop_front();
                checkOutput("gnt_a", 32'(gnt_a), 32'(mon_e.gnt));
                checkOutput("rvalid_a", 32'(rvalid_a), 32'(1'b1));
                checkOutput("rdata_a", 32'(rdata_a), 32'(mon_e.rdata));
            end
            grants_a    = grants_a + 1;
            grant_cyc_a = cyc;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t       vecs[10];
    logic [4:0] vals_b[32];

    initial begin
        bit   ok;
        int   target;
        int   t0;
        int   prev;
        int   g0;
        logic [31:0] seen;

        vecs[0] = '{4'b0001, 1'b0, 5'h00, 4'b0001, 5'h1C};
        vecs[1] = '{4'b0001, 1'b0, 5'h00, 4'b0001, 5'h06};
        vecs[2] = '{4'b1111, 1'b0, 5'h00, 4'b0010, 5'h14};
        vecs[3] = '{4'b1111, 1'b0, 5'h00, 4'b0100, 5'h04};
        vecs[4] = '{4'b1001, 1'b0, 5'h00, 4'b1000, 5'h01};
        vecs[5] = '{4'b0110, 1'b0, 5'h00, 4'b0010, 5'h0A};
        vecs[6] = '{4'b0101, 1'b0, 5'h00, 4'b0100, 5'h17};
        vecs[7] = '{4'b0100, 1'b1, 5'h01, 4'b0100, 5'h0A};
        vecs[8] = '{4'b0001, 1'b1, 5'h00, 4'b0001, 5'h1C};
        vecs[9] = '{4'b1000, 1'b0, 5'h00, 4'b1000, 5'h06};

        rst = 1'b0;
        applyStimulus(4'b0000, 1'b0, 5'h00);
        req_b       = '0;
        seed_load_b = 1'b0;
        seed_b      = 5'h00;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_gnt_a", 32'(gnt_a), 32'(4'b0000));
        checkOutput("reset_rvalid_a", 32'(rvalid_a), 32'(1'b0));
        checkOutput("reset_rdata_a", 32'(rdata_a), 32'(5'h00));
        checkOutput("reset_busy_a", 32'(busy_a), 32'(1'b0));
        checkOutput("reset_gnt_b", 32'(gnt_b), 32'(2'b00));
        checkOutput("reset_busy_b", 32'(busy_b), 32'(1'b0));
        rst = 1'b1;

        // Table-driven transactions, request dropped after each grant.
        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            @(negedge clk); #1;
            applyStimulus(vecs[i].req, vecs[i].sl, vecs[i].seed);
            e.gnt   = vecs[i].gnt;
            e.rdata = vecs[i].rdata;
            sbq.push_back(e);
            target = grants_a + 1;
            t0     = cyc;
            @(negedge clk); #1;
            seed_load_a = 1'b0;
            waitGrantA(target, 20, ok);
            if (ok) begin
                checkOutput("latency", 32'(grant_cyc_a - t0), 32'(STIR_A + 1 + (vecs[i].sl ? 1 : 0)));
            end
            applyStimulus(4'b0000, 1'b0, 5'h00);
            @(negedge clk); #1;
            checkOutput("rdata_hold", 32'(rdata_a), 32'(vecs[i].rdata));
            checkOutput("rvalid_low", 32'(rvalid_a), 32'(1'b0));
            checkOutput("busy_idle", 32'(busy_a), 32'(1'b0));
        end

        // Model state after the table: q = 0x06, last = 3.
        mq    = 5'h06;
        mlast = 3;

        // All four requesters held continuously: rotation with STIR+2 spacing.
        $display("[TB] held 4'b1111 rotation");
        for (int g = 0; g < 6; g++) pushPrediction(4'b1111);
        @(negedge clk); #1;
        req_a = 4'b1111;
        prev  = 0;
        for (int g = 0; g < 6; g++) begin
            waitGrantA(grants_a + 1, 20, ok);
            if (!ok) break;
            if (g > 0) checkOutput("spacing", 32'(grant_cyc_a - prev), 32'(STIR_A + 2));
            prev = grant_cyc_a;
        end
        req_a = 4'b0000;

        // seed_load pulsed during STEP must be ignored.
        $display("[TB] seed_load during STEP");
        @(negedge clk); #1;
        req_a = 4'b0010;
        pushPrediction(4'b0010);
        target = grants_a + 1;
        @(negedge clk); #1;
        checkOutput("busy_step", 32'(busy_a), 32'(1'b1));
        seed_load_a = 1'b1;
        seed_a      = 5'h01;
        @(negedge clk); #1;
        seed_load_a = 1'b0;
        seed_a      = 5'h00;
        waitGrantA(target, 20, ok);
        req_a = 4'b0000;

        // Reset in the middle of STEP aborts the grant and restores SEED.
        $display("[TB] reset mid-STEP");
        @(negedge clk); #1;
        req_a = 4'b0100;
        g0    = grants_a;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_gnt", 32'(gnt_a), 32'(4'b0000));
        checkOutput("abort_rvalid", 32'(rvalid_a), 32'(1'b0));
        checkOutput("abort_busy", 32'(busy_a), 32'(1'b0));
        checkOutput("abort_rdata", 32'(rdata_a), 32'(5'h00));
        req_a = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("no_grant_after_abort", 32'(grants_a), 32'(g0));
        mq    = SEED;
        mlast = NREQ_A - 1;
        req_a = 4'b0100;
        pushPrediction(4'b0100);
        waitGrantA(grants_a + 1, 20, ok);
        if (ok) checkOutput("post_reset_value", 32'(rdata_a), 32'(5'h1C));
        req_a = 4'b0000;

        // Zero seed loads SEED; then 100 grants to one persistent requester.
        $display("[TB] zero seed and 100 grants");
        @(negedge clk); #1;
        applyStimulus(4'b0000, 1'b1, 5'h00);
        @(negedge clk); #1;
        seed_load_a = 1'b0;
        mq = SEED;
        for (int g = 0; g < 100; g++) pushPrediction(4'b0001);
        req_a = 4'b0001;
        for (int g = 0; g < 100; g++) begin
            waitGrantA(grants_a + 1, 20, ok);
            if (!ok) break;
            checkOutput("rdata_nonzero", 32'(rdata_a != 5'd0), 32'(1'b1));
        end
        req_a = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'(0));

        // Instance B: STIR=1, walk the full LFSR period.
        $display("[TB] instance B period walk");
        @(negedge clk); #1;
        req_b = 2'b01;
        prev  = 0;
        seen  = '0;
        for (int g = 0; g < 32; g++) begin
            waitGrantB(10, ok);
            if (!ok) break;
            vals_b[g] = rdata_b;
            checkOutput("gnt_b", 32'(gnt_b), 32'(2'b01));
            if (g > 0) checkOutput("spacing_b", 32'(cyc - prev), 32'(STIR_B + 2));
            prev = cyc;
        end
        req_b = 2'b00;
        if (ok) begin
            checkOutput("first_b", 32'(vals_b[0]), 32'(5'h1F));
            for (int g = 0; g < 31; g++) begin
                checkOutput("nonzero_b", 32'(vals_b[g] != 5'd0), 32'(1'b1));
                seen[vals_b[g]] = 1'b1;
            end
            checkOutput("distinct_b", 32'($countones(seen)), 32'(31));
            checkOutput("period_b", 32'(vals_b[31]), 32'(vals_b[0]));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
